// File: rtl/jk_counter_ctrl_if.sv
// Command handshake bundle for the JK counter controller.
interface jk_counter_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/jk_counter_ctrl.sv
// JK counter controller: sequences CLEAR / LOAD / COUNT_UP / COUNT_DOWN
// commands onto a bank of JK flip-flops by computing the J/K excitation.

// One JK flip-flop, textbook behaviour, async active-low clear.
module jk_ff (
  input  logic clk,
  input  logic rstn,
  input  logic j,
  input  logic k,
  output logic q
);
  // hold / clear / set / toggle on the rising edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) q <= 1'b0;
    else begin
      case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end
endmodule

module jk_counter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  jk_counter_ctrl_if.slave cmd,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             wrap
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DN   = 2'b11;

  logic [1:0]       r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_step;
  logic             r_wrap;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_tup;
  logic [WIDTH-1:0] w_tdn;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;

  assign w_accept = (r_state == S_IDLE) && cmd.cmd_valid;
  // CLEAR/LOAD finish after one EXEC edge; counts finish when the step
  // counter is about to reach zero.
  assign w_last   = r_op[1] ? (r_step == WIDTH'(1)) : 1'b1;

  // ripple toggle masks: bit i toggles when all lower bits are 1 (up) / 0 (down)
  always_comb begin
    w_tup    = '0;
    w_tdn    = '0;
    w_tup[0] = 1'b1;
    w_tdn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      w_tup[i] = w_tup[i-1] & q[i-1];
      w_tdn[i] = w_tdn[i-1] & ~q[i-1];
    end
  end

  // J/K excitation: only driven in EXEC, bank holds otherwise
  always_comb begin
    w_j = '0;
    w_k = '0;
    if (r_state == S_EXEC) begin
      case (r_op)
        OP_CLR:  begin w_j = '0;     w_k = '1;      end
        OP_LOAD: begin w_j = r_data; w_k = ~r_data; end
        OP_UP:   begin w_j = w_tup;  w_k = w_tup;   end
        default: begin w_j = w_tdn;  w_k = w_tdn;   end
      endcase
    end
  end

  // command FSM, step counter and sticky wrap flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_data  <= '0;
      r_step  <= '0;
      r_wrap  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= cmd.cmd_op;
            r_data  <= cmd.cmd_data;
            r_step  <= cmd.cmd_data;
            r_wrap  <= 1'b0;
            // a zero-step count has nothing to execute
            r_state <= (cmd.cmd_op[1] && (cmd.cmd_data == '0)) ? S_DONE : S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_op[1]) r_step <= r_step - WIDTH'(1);
          if ((r_op == OP_UP && (&q)) || (r_op == OP_DN && ~(|q))) r_wrap <= 1'b1;
          if (w_last) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      jk_ff u_ff (
        .clk  (clk),
        .rstn (rstn),
        .j    (w_j[gi]),
        .k    (w_k[gi]),
        .q    (q[gi])
      );
    end
  endgenerate

  assign j_out         = w_j;
  assign k_out         = w_k;
  assign busy          = (r_state == S_EXEC);
  assign done          = (r_state == S_DONE);
  assign cmd.cmd_ready = (r_state == S_IDLE);
  assign wrap          = r_wrap;
endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Bench for jk_counter_ctrl: directed scenarios plus randomized commands
// checked against an arithmetic model of the bank value.
module tb_jk_counter_ctrl;
  localparam int W = 4;

  logic         clk  = 1'b0;
  logic         rstn = 1'b1;
  logic [W-1:0] q, j_out, k_out;
  logic         busy, done, wrap;

  jk_counter_ctrl_if #(.WIDTH(W)) cif ();

  jk_counter_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .cmd   (cif),
    .q     (q),
    .j_out (j_out),
    .k_out (k_out),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // per-cycle trace of one command, index i = cycle after edge t+i
  logic [W-1:0] qs[$], js[$], ks[$];
  logic         bs[$], ds[$], ws[$];
  int           t_done;

  // Issue one command from a negedge and record outputs until done;
  // returns at the negedge of the DONE cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] d);
    int cyc;
    qs.delete(); js.delete(); ks.delete(); bs.delete(); ds.delete(); ws.delete();
    t_done = -1;
    cyc = 0;
    while (cif.cmd_ready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    if (cyc >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout: cmd_ready=%b after %0d cycles, required 1", cif.cmd_ready, cyc);
      return;
    end
    cif.cmd_valid = 1'b1; cif.cmd_op = op; cif.cmd_data = d;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    cyc = 0;
    while (t_done < 0) begin
      @(negedge clk);
      qs.push_back(q); js.push_back(j_out); ks.push_back(k_out);
      bs.push_back(busy); ds.push_back(done); ws.push_back(wrap);
      if (done === 1'b1) t_done = cyc;
      else if (cyc >= 40) begin
        n_tests++; n_fail++;
        $display("FAIL done_timeout: no done within %0d cycles of op %0d", cyc, op);
        return;
      end
      cyc++;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #2;
    rstn = 1'b0; #1;
    n_tests++;
    if ({q, cif.cmd_ready, done, wrap, busy} !== {4'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: q=%h rdy=%b done=%b wrap=%b busy=%b, required 0 1 0 0 0",
               q, cif.cmd_ready, done, wrap, busy);
    end
    @(negedge clk); rstn = 1'b1; #1;
    n_tests++;
    if ({q, cif.cmd_ready, done, wrap, j_out, k_out} !== {4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_release: q=%h rdy=%b done=%b wrap=%b j=%h k=%h",
               q, cif.cmd_ready, done, wrap, j_out, k_out);
    end
    @(negedge clk);
  endtask

  task automatic test_load_count();
    run_cmd(2'b01, 4'b1010);
    n_tests++;
    if ({t_done, js[0], ks[0], bs[0], qs[1]} !== {32'sd1, 4'b1010, 4'b0101, 1'b1, 4'b1010}) begin
      n_fail++;
      $display("FAIL load_exec: done_at=%0d j=%b k=%b busy=%b q=%b, required 1 1010 0101 1 1010",
               t_done, js[0], ks[0], bs[0], qs[1]);
    end
    @(negedge clk);
    n_tests++;
    if ({done, cif.cmd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL load_single_pulse: done=%b rdy=%b, required 0 1", done, cif.cmd_ready);
    end
    run_cmd(2'b10, 4'd3);
    n_tests++;
    if ({t_done, qs[1], qs[2], qs[3], ws[3], bs[0], bs[2]} !==
        {32'sd3, 4'b1011, 4'b1100, 4'b1101, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL count_up3: done_at=%0d q=%b,%b,%b wrap=%b busy=%b%b, required 3 1011,1100,1101 0 11",
               t_done, qs[1], qs[2], qs[3], ws[3], bs[0], bs[2]);
    end
    @(negedge clk);
    n_tests++;
    if ({done, cif.cmd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL count_single_pulse: done=%b rdy=%b, required 0 1", done, cif.cmd_ready);
    end
  endtask

  task automatic test_wrap_and_clear();
    run_cmd(2'b01, 4'b1110);
    @(negedge clk);
    run_cmd(2'b10, 4'd3);
    n_tests++;
    if ({qs[1], qs[2], qs[3], ws[1], ws[2], ws[3]} !== {4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_up: q=%b,%b,%b wrap=%b%b%b, required 1111,0000,0001 011",
               qs[1], qs[2], qs[3], ws[1], ws[2], ws[3]);
    end
    @(negedge clk);
    n_tests++;
    if (wrap !== 1'b1) begin
      n_fail++; $display("FAIL wrap_sticky: wrap=%b, required 1", wrap);
    end
    run_cmd(2'b11, 4'd2);
    n_tests++;
    if ({ws[0], ws[1], qs[1], qs[2], ws[2]} !== {1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_down: wrap0=%b wrap1=%b q=%b,%b wrap2=%b, required 0 0 0000,1111 1",
               ws[0], ws[1], qs[1], qs[2], ws[2]);
    end
    @(negedge clk);
    run_cmd(2'b00, 4'b1011);
    n_tests++;
    if ({js[0], ks[0], qs[1], ws[1]} !== {4'b0000, 4'b1111, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL clear: j=%b k=%b q=%b wrap=%b, required 0000 1111 0000 0", js[0], ks[0], qs[1], ws[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_count_zero();
    run_cmd(2'b01, 4'b0110);
    @(negedge clk);
    run_cmd(2'b10, 4'd0);
    n_tests++;
    if ({t_done, bs[0], qs[0], js[0], ks[0]} !== {32'sd0, 1'b0, 4'b0110, 4'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL count_zero: done_at=%0d busy=%b q=%b j=%h k=%h, required 0 0 0110 0 0",
               t_done, bs[0], qs[0], js[0], ks[0]);
    end
    @(negedge clk);
    n_tests++;
    if ({cif.cmd_ready, busy, q} !== {1'b1, 1'b0, 4'b0110}) begin
      n_fail++; $display("FAIL count_zero_after: rdy=%b busy=%b q=%b", cif.cmd_ready, busy, q);
    end
  endtask

  task automatic test_back_to_back();
    cif.cmd_valid = 1'b1; cif.cmd_op = 2'b01; cif.cmd_data = 4'd3;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, cif.cmd_ready} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_exec: busy=%b rdy=%b, required 1 0", busy, cif.cmd_ready);
    end
    @(negedge clk);
    n_tests++;
    if ({done, cif.cmd_ready, q} !== {1'b1, 1'b0, 4'd3}) begin
      n_fail++; $display("FAIL b2b_done: done=%b rdy=%b q=%h, required 1 0 3", done, cif.cmd_ready, q);
    end
    @(negedge clk);
    n_tests++;
    if ({busy, done, cif.cmd_ready} !== 3'b001) begin
      n_fail++; $display("FAIL b2b_idle: busy=%b done=%b rdy=%b, required 0 0 1", busy, done, cif.cmd_ready);
    end
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_reaccept: busy=%b, required 1", busy);
    end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_abort();
    run_cmd(2'b00, 4'd0);
    @(negedge clk);
    cif.cmd_valid = 1'b1; cif.cmd_op = 2'b10; cif.cmd_data = 4'd10;
    @(posedge clk); #1;
    cif.cmd_op = 2'b01; cif.cmd_data = 4'b0101;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({q, busy, cif.cmd_ready} !== {4'd4, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL abort_ignore: q=%h busy=%b rdy=%b, required 4 1 0", q, busy, cif.cmd_ready);
    end
    #2 rstn = 1'b0; #1;
    n_tests++;
    if ({q, busy, done, cif.cmd_ready} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_reset: q=%h busy=%b done=%b rdy=%b, required 0 0 0 1", q, busy, done, cif.cmd_ready);
    end
    cif.cmd_valid = 1'b0;
    @(negedge clk); rstn = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({q, busy, done, cif.cmd_ready} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_no_resume: q=%h busy=%b done=%b rdy=%b, required 0 0 0 1", q, busy, done, cif.cmd_ready);
    end
  endtask

  task automatic test_random();
    int mq;
    int n, eq, nq;
    logic [1:0] op;
    logic [W-1:0] d;
    logic [W-1:0] ej, ek;
    logic ew;
    run_cmd(2'b00, 4'd0);
    @(negedge clk);
    mq = 0;
    for (int c = 0; c < 40; c++) begin
      op = 2'($urandom_range(0, 3));
      d  = W'($urandom_range(0, 15));
      n  = op[1] ? int'(d) : 1;
      run_cmd(op, d);
      n_tests++;
      if (t_done != n) begin
        n_fail++; $display("FAIL rnd_latency: cmd %0d op %0d data %0d done_at=%0d, required %0d", c, op, d, t_done, n);
      end else begin
        for (int i = 0; i <= n; i++) begin
          // value held during cycle i
          case (op)
            2'b00:   eq = (i == 0) ? mq : 0;
            2'b01:   eq = (i == 0) ? mq : int'(d);
            2'b10:   eq = (mq + i) % 16;
            default: eq = ((mq - i) % 16 + 16) % 16;
          endcase
          // value after the following edge, for the toggle mask
          case (op)
            2'b10:   nq = (mq + i + 1) % 16;
            2'b11:   nq = ((mq - i - 1) % 16 + 16) % 16;
            default: nq = eq;
          endcase
          if (i == n)           begin ej = '0; ek = '0; end
          else if (op == 2'b00) begin ej = '0; ek = '1; end
          else if (op == 2'b01) begin ej = d;  ek = ~d; end
          else                  begin ej = W'(eq ^ nq); ek = ej; end
          n_tests++;
          if ({qs[i], bs[i], ds[i], js[i], ks[i]} !== {W'(eq), (i < n), (i == n), ej, ek}) begin
            n_fail++;
            $display("FAIL rnd_cycle: cmd %0d op %0d data %0d cyc %0d q=%h busy=%b done=%b j=%h k=%h, required %h %b %b %h %h",
                     c, op, d, i, qs[i], bs[i], ds[i], js[i], ks[i], W'(eq), (i < n), (i == n), ej, ek);
          end
        end
        ew = (op == 2'b10) ? (mq + n > 15) : (op == 2'b11) ? (n > mq) : 1'b0;
        n_tests++;
        if (ws[n] !== ew) begin
          n_fail++; $display("FAIL rnd_wrap: cmd %0d op %0d data %0d wrap=%b, required %b", c, op, d, ws[n], ew);
        end
      end
      case (op)
        2'b00:   mq = 0;
        2'b01:   mq = int'(d);
        2'b10:   mq = (mq + n) % 16;
        default: mq = ((mq - n) % 16 + 16) % 16;
      endcase
      @(negedge clk);
      n_tests++;
      if ({done, cif.cmd_ready} !== 2'b01) begin
        n_fail++; $display("FAIL rnd_pulse: cmd %0d done=%b rdy=%b, required 0 1", c, done, cif.cmd_ready);
      end
    end
  endtask

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'b00;
    cif.cmd_data  = '0;
    test_reset();
    test_load_count();
    test_wrap_and_clear();
    test_count_zero();
    test_back_to_back();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
